// File: rtl/npx_pkg.sv
// npx_pkg: state encoding, GRB field layout and brightness limits
// shared by the WS2812B frame scheduler and its channel scaler.
package npx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    SEND,
    LATCH
  } npx_state_t;

  localparam int G_HI = 23;
  localparam int G_LO = 16;
  localparam int R_HI = 15;
  localparam int R_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  localparam logic [2:0] LVL_MAX = 3'd4;

  // Right-shift amount for a level; 5..7 saturate to full scale.
  function automatic logic [2:0] lvl_shift(input logic [2:0] lvl);
    return (lvl >= LVL_MAX) ? 3'd0 : LVL_MAX - lvl;
  endfunction

endpackage

// File: rtl/npx_dim.sv
// npx_dim: combinational per-channel brightness scaler.
// Ports: lvl (0..4, >4 = 4), din {G,R,B}, dout scaled {G,R,B}.
module npx_dim
  import npx_pkg::*;
(
  input  logic [2:0]  lvl,
  input  logic [23:0] din,
  output logic [23:0] dout
);

  logic [2:0] s;

  always_comb begin
    s = lvl_shift(lvl);
    // Each channel shifts alone so no bits bleed across bytes.
    dout[G_HI:G_LO] = din[G_HI:G_LO] >> s;
    dout[R_HI:R_LO] = din[R_HI:R_LO] >> s;
    dout[B_HI:B_LO] = din[B_HI:B_LO] >> s;
  end

endmodule

// File: rtl/npx_frame_sched.sv
// npx_frame_sched: walks the pixel buffer, scales each GRB word and
// hands it to the serializer over valid/ready, then holds the latch gap.
// Ports: clk, rst (async high), start, bright_lvl -> rd_en/rd_addr,
// rd_data <- buffer, px_data/px_valid/px_ready to serializer,
// busy, frame_done. Option: NPX_AUTO_REFRESH_EN repeats frames forever.
module npx_frame_sched
  import npx_pkg::*;
#(
  parameter int NUM_LEDS     = 60,
  parameter int ADDR_W       = 6,
  parameter int LATCH_CYCLES = 3600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        bright_lvl,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic [23:0]       px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W =
    (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(LATCH_CYCLES - 1);

  npx_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        lvl_q, lvl_nxt;
  logic [23:0]       px_q, px_nxt;
  logic [23:0]       dim_out;

  npx_dim u_dim (
    .lvl  (lvl_q),
    .din  (rd_data),
    .dout (dim_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      lvl_q <= LVL_MAX;
      px_q  <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      cnt   <= cnt_nxt;
      lvl_q <= lvl_nxt;
      px_q  <= px_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    cnt_nxt    = cnt;
    lvl_nxt    = lvl_q;
    px_nxt     = px_q;
    rd_en      = 1'b0;
    px_valid   = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          lvl_nxt   = bright_lvl;
          addr_nxt  = '0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        rd_en     = 1'b1;
        state_nxt = CAPT;
      end
      CAPT: begin
        px_nxt    = dim_out;
        state_nxt = SEND;
      end
      SEND: begin
        px_valid = 1'b1;
        if (px_ready) begin
          if (addr == LAST_ADDR) begin
            cnt_nxt   = '0;
            state_nxt = LATCH;
          end else begin
            addr_nxt  = addr + 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      LATCH: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_CNT) begin
          frame_done = 1'b1;
`ifdef NPX_AUTO_REFRESH_EN
          lvl_nxt   = bright_lvl;
          addr_nxt  = '0;
          state_nxt = FETCH;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_addr = addr;
  assign px_data = px_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_npx_frame_sched.sv
// tb_npx_frame_sched: directed bench with a scoreboard of expected
// pixel words for npx_frame_sched (4 LEDs, 8-cycle latch gap).
module tb_npx_frame_sched;

  localparam int NL = 4;
  localparam int LC = 8;
  localparam int FRAME = 3 * NL + LC;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  bright_lvl;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [23:0] rd_data;
  logic [23:0] px_data;
  logic        px_valid;
  logic        px_ready;
  logic        busy;
  logic        frame_done;

  logic [23:0] mem [NL];
  logic [23:0] q[$];
  int errors = 0;
  int checks = 0;
  int nwords = 0;

  always #5 clk = ~clk;

  npx_frame_sched #(
    .NUM_LEDS     (NL),
    .ADDR_W       (2),
    .LATCH_CYCLES (LC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bright_lvl (bright_lvl),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .px_data    (px_data),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always @(posedge clk)
    if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] scale(input logic [23:0] w,
                                        input int lvl);
    int l;
    int div;
    l = (lvl > 4) ? 4 : lvl;
    div = 1 << (4 - l);
    scale = {8'(int'(w[23:16]) / div),
             8'(int'(w[15:8]) / div),
             8'(int'(w[7:0]) / div)};
  endfunction

  // Sample just after the negedge, seeing what the next posedge will see.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (rd_en) chk("rd_addr_range", {31'd0, rd_addr < 2'(NL - 1) ||
                     rd_addr == 2'(NL - 1)}, 32'd1);
      if (px_valid && px_ready) begin
        logic [31:0] e;
        e = (q.size() > 0) ? {8'd0, q.pop_front()} : 32'hDEADBEEF;
        chk("word", {8'd0, px_data}, e);
        nwords++;
      end
    end
  end

  task automatic push_frame(input int lvl);
    for (int i = 0; i < NL; i++) q.push_back(scale(mem[i], lvl));
  endtask

  task automatic start_frame(input logic [2:0] lvl);
    bright_lvl = lvl;
    start = 1'b1;
    push_frame(int'(lvl));
    @(negedge clk);
    start = 1'b0;
    chk("fetch_rd_en", {31'd0, rd_en}, 32'd1);
    chk("fetch_addr0", {30'd0, rd_addr}, 32'd0);
  endtask

  // Counts cycles inclusively from the FETCH cycle to frame_done.
  task automatic wait_done(output int cyc, output int fv);
    cyc = 1;
    fv = 0;
    while (!frame_done && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (px_valid && fv == 0) fv = cyc;
    end
    if (!frame_done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc, fv, n;
    logic [23:0] held;
    logic seen;
    mem[0] = 24'hFFFFFF;
    mem[1] = 24'h123456;
    mem[2] = 24'h000000;
    mem[3] = 24'h80FF01;
    rst = 1'b1;
    start = 1'b0;
    bright_lvl = 3'd4;
    px_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_rd_addr", {30'd0, rd_addr}, 32'd0);
    chk("rst_px_data", {8'd0, px_data}, 32'd0);
    chk("rst_px_valid", {31'd0, px_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef NPX_AUTO_REFRESH_EN
    push_frame(4);
    push_frame(4);
    start_frame(3'd4);
    wait_done(cyc, fv);
    chk("ar_first_len", cyc, FRAME);
    seen = 1'b0;
    for (int f = 0; f < 2; f++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (!busy) seen = 1'b1;
        if (n == 2) start = 1'b1;
        if (n == 3) start = 1'b0;
      end while (!frame_done && n < 500);
      chk("ar_period", n, FRAME);
    end
    chk("ar_busy_held", {31'd0, seen}, 32'd0);
    chk("ar_sb_empty", q.size(), 32'd0);
`else
    // Unity level, ready tied high.
    start_frame(3'd4);
    wait_done(cyc, fv);
    chk("l4_first_valid", fv, 32'd3);
    chk("l4_frame_len", cyc, FRAME);
    @(negedge clk);
    chk("l4_busy_drop", {31'd0, busy}, 32'd0);
    chk("l4_words", nwords, NL);
    chk("l4_sb_empty", q.size(), 32'd0);

    // Level 2: quarter brightness.
    start_frame(3'd2);
    wait_done(cyc, fv);
    chk("l2_frame_len", cyc, FRAME);
    chk("l2_sb_empty", q.size(), 32'd0);
    @(negedge clk);

    // Level 7 clamps to unity.
    start_frame(3'd7);
    wait_done(cyc, fv);
    chk("l7_sb_empty", q.size(), 32'd0);
    @(negedge clk);

    // Backpressure on word 1.
    n = nwords;
    start_frame(3'd4);
    cyc = 0;
    while (nwords == n && cyc < 50) begin @(negedge clk); cyc++; end
    px_ready = 1'b0;
    cyc = 0;
    while (!px_valid && cyc < 50) begin @(negedge clk); cyc++; end
    held = px_data;
    chk("bp_word1", {8'd0, held}, {8'd0, mem[1]});
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, px_valid}, 32'd1);
      chk("bp_stable", {8'd0, px_data}, {8'd0, held});
      chk("bp_addr", {30'd0, rd_addr}, 32'd1);
      if (i < 4) @(negedge clk);
    end
    px_ready = 1'b1;
    wait_done(cyc, fv);
    chk("bp_sb_empty", q.size(), 32'd0);
    @(negedge clk);

    // Mid-frame level change and dropped start.
    start_frame(3'd4);
    repeat (3) @(negedge clk);
    bright_lvl = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    wait_done(cyc, fv);
    chk("mid_sb_empty", q.size(), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_en || busy) seen = 1'b1;
    end
    chk("no_second_frame", {31'd0, seen}, 32'd0);
    start_frame(3'd0);
    wait_done(cyc, fv);
    chk("l0_sb_empty", q.size(), 32'd0);
    @(negedge clk);

    // Asynchronous reset while in SEND.
    px_ready = 1'b0;
    start_frame(3'd4);
    cyc = 0;
    while (!px_valid && cyc < 50) begin @(negedge clk); cyc++; end
    chk("rst_pre_valid", {31'd0, px_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, px_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, frame_done}, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    px_ready = 1'b1;
    @(negedge clk);
    chk("arst_idle", {31'd0, busy}, 32'd0);
    start_frame(3'd4);
    wait_done(cyc, fv);
    chk("arst_frame_len", cyc, FRAME);
    chk("arst_sb_empty", q.size(), 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
